if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. It holds a pre-IF next-PC generator and an IF pipeline slot. It drives the synchronous instruction SRAM, consumes the decode stage's branch bus, and buffers fetched instructions and pending redirects across decode back-pressure. It delivers `{pc, inst}` to decode under the valid/allowin handshake.

---
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage.sv | 108 ++++++++++
 tb/tb_if_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's external handshake signals: the decode-side
// valid/allowin/branch bus and the synchronous instruction SRAM port.
interface if_stage_if #(
  parameter int BR_BUS_WD       = 33,
  parameter int FS_TO_DS_BUS_WD = 64
);
  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_en;
  logic [3:0]                 inst_sram_wen;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_wdata;
  logic [31:0]                inst_sram_rdata;

  // Fetch stage side
  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus,
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );

  // Decode stage / SRAM side
  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus,
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: pre-IF next-PC generation, IF slot, and buffers
// that hold a fetched word and a pending branch target across decode stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input logic        clk,
  input logic        resetn,
  if_stage_if.master bus
);

  // Pre-IF and IF state
  logic        to_fs_valid;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        br_buf_valid;
  logic [31:0] br_buf_target;
  logic        inst_buf_valid;
  logic [31:0] inst_buf;
  logic        req_done;      // a request was accepted on the previous edge

  // Combinational datapath
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fs_to_ds_valid;
  logic        handshake;
  logic        req;
  logic [31:0] fs_inst;

  assign br_taken       = bus.br_bus[32];
  assign br_target      = bus.br_bus[31:0];
  assign seq_pc         = fs_pc + 32'd4;
  // A buffered redirect outranks a live one: it was seen first.
  assign nextpc         = br_buf_valid ? br_buf_target :
                          br_taken     ? br_target     : seq_pc;
  assign fs_ready_go    = 1'b1;
  assign fs_allowin     = !fs_valid || (fs_ready_go && bus.ds_allowin);
  assign fs_to_ds_valid = fs_valid && fs_ready_go;
  assign handshake      = fs_to_ds_valid && bus.ds_allowin;
  assign req            = to_fs_valid && fs_allowin;
  // SRAM data is only valid the cycle after the request; afterwards the
  // captured copy is used.
  assign fs_inst        = inst_buf_valid ? inst_buf : bus.inst_sram_rdata;

  assign bus.fs_to_ds_valid  = fs_to_ds_valid;
  assign bus.fs_to_ds_bus    = {fs_pc, fs_inst};
  assign bus.inst_sram_en    = req;
  assign bus.inst_sram_wen   = 4'h0;
  assign bus.inst_sram_addr  = nextpc;
  assign bus.inst_sram_wdata = 32'h0;

  // Pre-IF becomes valid on the first edge after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) to_fs_valid <= 1'b0;
    else         to_fs_valid <= 1'b1;
  end

  // IF slot: load on an accepted request, drain when nothing comes in
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (req) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
    end else if (fs_allowin) begin
      fs_valid <= 1'b0;
    end
  end

  // Marks the cycle in which SRAM read data belongs to the IF slot
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) req_done <= 1'b0;
    else         req_done <= req;
  end

  // Branch buffer: hold a redirect that could not be issued this cycle;
  // the first one held wins until it is issued
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_buf_valid  <= 1'b0;
      br_buf_target <= 32'h0;
    end else if (req) begin
      br_buf_valid  <= 1'b0;
    end else if (br_taken && !br_buf_valid) begin
      br_buf_valid  <= 1'b1;
      br_buf_target <= br_target;
    end
  end

  // Instruction buffer: capture the one-cycle SRAM data if decode stalls,
  // release it when decode finally takes the instruction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_buf_valid <= 1'b0;
      inst_buf       <= 32'h0;
    end else if (handshake) begin
      inst_buf_valid <= 1'b0;
    end else if (req_done) begin
      inst_buf_valid <= 1'b1;
      inst_buf       <= bus.inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table-driven per-cycle vectors plus hand sequences
// for reset behaviour and asynchronous reset with both buffers loaded.
module tb_if_stage;

  typedef struct {
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        force_bad;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic        force_bad;
  logic [31:0] sram_q;
  int          n_cmp;
  int          n_err;

  if_stage_if bif ();

  if_stage #(.RESET_PC(32'hbfc00000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: returns the requested address as data, one cycle later
  always @(posedge clk) begin
    if (bif.inst_sram_en) sram_q <= bif.inst_sram_addr;
  end
  assign bif.inst_sram_rdata = force_bad ? 32'hdeadbeef : sram_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ds, input logic br, input logic [31:0] tgt,
                              input logic fb, input logic en, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc, input logic [31:0] inst);
    vec_t r;
    r.ds_allowin = ds; r.br_taken = br; r.br_target = tgt; r.force_bad = fb;
    r.exp_en = en; r.exp_addr = addr; r.exp_valid = v; r.exp_pc = pc; r.exp_inst = inst;
    return r;
  endfunction

  // Drive one cycle's inputs after the falling edge, check before the rising edge
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    bif.ds_allowin = v.ds_allowin;
    bif.br_bus     = {v.br_taken, v.br_target};
    force_bad      = v.force_bad;
    #2;
    $display("%s: en=%0b addr=%h valid=%0b pc=%h inst=%h", tag, bif.inst_sram_en,
             bif.inst_sram_addr, bif.fs_to_ds_valid, bif.fs_to_ds_bus[63:32], bif.fs_to_ds_bus[31:0]);
    chk({tag, " en"}, {31'h0, bif.inst_sram_en}, {31'h0, v.exp_en});
    if (v.exp_en) chk({tag, " addr"}, bif.inst_sram_addr, v.exp_addr);
    chk({tag, " valid"}, {31'h0, bif.fs_to_ds_valid}, {31'h0, v.exp_valid});
    if (v.exp_valid) begin
      chk({tag, " pc"}, bif.fs_to_ds_bus[63:32], v.exp_pc);
      chk({tag, " inst"}, bif.fs_to_ds_bus[31:0], v.exp_inst);
    end
  endtask

  // Release reset on a falling edge and confirm no request before the first rising edge
  task automatic release_reset(input string tag);
    @(negedge clk);
    resetn = 1'b1;
    #2;
    $display("%s: release en=%0b", tag, bif.inst_sram_en);
    chk({tag, " en before first edge"}, {31'h0, bif.inst_sram_en}, 32'h0);
  endtask

  vec_t tab_a[8];
  vec_t tab_b[13];

  initial begin
    n_cmp = 0; n_err = 0;
    resetn = 1'b0; force_bad = 1'b0; sram_q = 32'h0;
    bif.ds_allowin = 1'b1; bif.br_bus = 33'h0;

    // Flow, then a 3-cycle stall at pc bfc00008 with corrupted SRAM data
    tab_a[0] = mk(1,0,0,0, 1,32'hbfc00000, 0,32'h0,32'h0);
    tab_a[1] = mk(1,0,0,0, 1,32'hbfc00004, 1,32'hbfc00000,32'hbfc00000);
    tab_a[2] = mk(1,0,0,0, 1,32'hbfc00008, 1,32'hbfc00004,32'hbfc00004);
    tab_a[3] = mk(0,0,0,0, 0,32'h0,        1,32'hbfc00008,32'hbfc00008);
    tab_a[4] = mk(0,0,0,1, 0,32'h0,        1,32'hbfc00008,32'hbfc00008);
    tab_a[5] = mk(0,0,0,1, 0,32'h0,        1,32'hbfc00008,32'hbfc00008);
    tab_a[6] = mk(1,0,0,1, 1,32'hbfc0000c, 1,32'hbfc00008,32'hbfc00008);
    tab_a[7] = mk(1,0,0,0, 1,32'hbfc00010, 1,32'hbfc0000c,32'hbfc0000c);

    // Branch with delay slot, branch buffered across a stall, PC wrap
    tab_b[0]  = mk(1,0,0,0, 1,32'hbfc00000, 0,32'h0,32'h0);
    tab_b[1]  = mk(1,0,0,0, 1,32'hbfc00004, 1,32'hbfc00000,32'hbfc00000);
    tab_b[2]  = mk(1,0,0,0, 1,32'hbfc00008, 1,32'hbfc00004,32'hbfc00004);
    tab_b[3]  = mk(1,1,32'hbfc00100,0, 1,32'hbfc00100, 1,32'hbfc00008,32'hbfc00008);
    tab_b[4]  = mk(1,0,0,0, 1,32'hbfc00104, 1,32'hbfc00100,32'hbfc00100);
    tab_b[5]  = mk(0,1,32'hbfc00200,0, 0,32'h0, 1,32'hbfc00104,32'hbfc00104);
    tab_b[6]  = mk(0,0,0,0, 0,32'h0,        1,32'hbfc00104,32'hbfc00104);
    tab_b[7]  = mk(1,0,0,0, 1,32'hbfc00200, 1,32'hbfc00104,32'hbfc00104);
    tab_b[8]  = mk(1,0,0,0, 1,32'hbfc00204, 1,32'hbfc00200,32'hbfc00200);
    tab_b[9]  = mk(1,1,32'hfffffff8,0, 1,32'hfffffff8, 1,32'hbfc00204,32'hbfc00204);
    tab_b[10] = mk(1,0,0,0, 1,32'hfffffffc, 1,32'hfffffff8,32'hfffffff8);
    tab_b[11] = mk(1,0,0,0, 1,32'h00000000, 1,32'hfffffffc,32'hfffffffc);
    tab_b[12] = mk(1,0,0,0, 1,32'h00000004, 1,32'h00000000,32'h00000000);

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    $display("reset: en=%0b valid=%0b addr=%h pc=%h", bif.inst_sram_en, bif.fs_to_ds_valid,
             bif.inst_sram_addr, bif.fs_to_ds_bus[63:32]);
    chk("reset en", {31'h0, bif.inst_sram_en}, 32'h0);
    chk("reset valid", {31'h0, bif.fs_to_ds_valid}, 32'h0);
    chk("reset nextpc", bif.inst_sram_addr, 32'hbfc00000);
    chk("reset fs_pc", bif.fs_to_ds_bus[63:32], 32'hbfbffffc);
    chk("wen tied", {28'h0, bif.inst_sram_wen}, 32'h0);
    chk("wdata tied", bif.inst_sram_wdata, 32'h0);

    release_reset("seqA");
    for (int i = 0; i < 8; i++) run_vec(tab_a[i], $sformatf("A%0d", i));

    // Load both buffers: stall with a branch pulse right after an accepted request
    run_vec(mk(0,1,32'h12340000,0, 0,32'h0, 1,32'hbfc00010,32'hbfc00010), "load0");
    run_vec(mk(0,0,0,0, 0,32'h0, 1,32'hbfc00010,32'hbfc00010), "load1");

    // Asynchronous reset mid-stall, checked before any clock edge
    #1;
    resetn = 1'b0;
    #1;
    $display("async reset: en=%0b valid=%0b addr=%h", bif.inst_sram_en, bif.fs_to_ds_valid,
             bif.inst_sram_addr);
    chk("async en", {31'h0, bif.inst_sram_en}, 32'h0);
    chk("async valid", {31'h0, bif.fs_to_ds_valid}, 32'h0);
    chk("async nextpc", bif.inst_sram_addr, 32'hbfc00000);
    chk("async fs_pc", bif.fs_to_ds_bus[63:32], 32'hbfbffffc);
    bif.ds_allowin = 1'b1;
    bif.br_bus     = 33'h0;
    repeat (2) @(negedge clk);

    release_reset("seqB");
    for (int i = 0; i < 13; i++) run_vec(tab_b[i], $sformatf("B%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
